// File: rtl/gpmc_pkg.sv
// gpmc_pkg: shared types and defaults for the GPMC initiator.
//   state_t      - access sequencer states
//   strobes_t    - the four active-low bus strobes, grouped
//   STROBES_IDLE - all strobes deasserted
//   DEF_*        - default timing, in gpmc_clk periods (CLK_HALF in clk cycles)
package gpmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_TURN
    } state_t;

    typedef struct packed {
        logic csn;
        logic advn;
        logic wein;
        logic oen;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = 4'b1111;

    localparam int DEF_CLK_HALF = 1;
    localparam int DEF_RD_LAT   = 2;
    localparam int DEF_WR_HOLD  = 1;
    localparam int DEF_TURN     = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gpmc_clkgen.sv
// gpmc_clkgen: bus clock generator for the GPMC initiator.
//   clk, rst   - system clock, synchronous active-high reset
//   en         - run; when low the counter is cleared and gpmc_clk held low
//   gpmc_clk   - registered bus clock: low for CLK_HALF cycles, then high
//   period_end - high on the last clk cycle of each bus period
module gpmc_clkgen
    import gpmc_pkg::*;
#(
    parameter int CLK_HALF = DEF_CLK_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic gpmc_clk,
    output logic period_end
);

    localparam int PERIOD = 2 * CLK_HALF;
    localparam int CNT_W  = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
        // Registering the clock from the next count keeps gpmc_clk glitch-free
        // while still lining up with cnt_q in the same cycle.
        clk_d = (cnt_d >= CNT_W'(CLK_HALF));
    end

    assign period_end = en && (cnt_q == CNT_W'(PERIOD - 1));
    assign gpmc_clk   = clk_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

endmodule

// File: rtl/gpmc_master.sv
// gpmc_master: synchronous GPMC initiator, one single-word access per request.
//   clk, rst                 - system clock, synchronous active-high reset
//   req_valid/ready/we/addr/wdata - request handshake and payload
//   rsp_valid, rsp_rdata     - one-cycle completion pulse, read data
//   gpmc_clk/csn/advn/wein/oen - bus clock and active-low strobes (registered)
//   gpmc_ad_o, gpmc_ad_oe    - AD drive value and enable (tristate built above)
//   gpmc_ad_i                - AD sampled value
//   gpmc_wait                - only with GPMC_WAIT_EN: stretches DATA by periods
// Sequence: IDLE -> ADDR (1 period) -> DATA (WR_HOLD/RD_LAT periods) -> TURN.
// Define GPMC_WAIT_EN to add the gpmc_wait input.
module gpmc_master
    import gpmc_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CLK_HALF   = DEF_CLK_HALF,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int WR_HOLD    = DEF_WR_HOLD,
    parameter int TURN       = DEF_TURN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  gpmc_clk,
    output logic                  gpmc_csn,
    output logic                  gpmc_advn,
    output logic                  gpmc_wein,
    output logic                  gpmc_oen,
    output logic [DATA_WIDTH-1:0] gpmc_ad_o,
    output logic                  gpmc_ad_oe,
    input  logic [DATA_WIDTH-1:0] gpmc_ad_i
`ifdef GPMC_WAIT_EN
    ,
    input  logic                  gpmc_wait
`endif
);

    localparam int PH_W = $clog2(max3(RD_LAT, WR_HOLD, TURN) + 1);

    state_t                state_q, state_d;
    logic [PH_W-1:0]       ph_cnt_q, ph_cnt_d;
    logic [PH_W-1:0]       ph_last;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    strobes_t              strb_q, strb_d;
    logic                  ad_oe_q, ad_oe_d;
    logic [DATA_WIDTH-1:0] ad_o_q, ad_o_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  period_end;
    logic                  last_period;
    logic                  data_wait;

`ifdef GPMC_WAIT_EN
    assign data_wait = gpmc_wait;
`else
    assign data_wait = 1'b0;
`endif

    gpmc_clkgen #(
        .CLK_HALF (CLK_HALF)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q != ST_IDLE),
        .gpmc_clk   (gpmc_clk),
        .period_end (period_end)
    );

    // Sequencer: phases advance only on period boundaries; ph_cnt counts
    // completed periods within the current phase.
    always_comb begin
        state_d     = state_q;
        ph_cnt_d    = ph_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        ph_last     = '0;

        case (state_q)
            ST_DATA: ph_last = we_q ? PH_W'(WR_HOLD - 1) : PH_W'(RD_LAT - 1);
            ST_TURN: ph_last = PH_W'(TURN - 1);
            default: ph_last = '0;
        endcase
        last_period = period_end && (ph_cnt_q == ph_last);

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    ph_cnt_d = '0;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR, ST_TURN: begin
                if (last_period) begin
                    ph_cnt_d = '0;
                    state_d  = (state_q == ST_ADDR) ? ST_DATA : ST_IDLE;
                end else if (period_end) begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            ST_DATA: begin
                // A waited period is simply repeated: the count does not move,
                // so the read sample point slides out with it.
                if (period_end && !data_wait) begin
                    if (ph_cnt_q == ph_last) begin
                        ph_cnt_d    = '0;
                        state_d     = ST_TURN;
                        rsp_valid_d = 1'b1;
                        if (!we_q) begin
                            rdata_d = gpmc_ad_i;
                        end
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so they
    // change exactly with state_q and never glitch.
    always_comb begin
        strb_d  = STROBES_IDLE;
        ad_oe_d = 1'b0;
        ad_o_d  = '0;
        ready_d = 1'b0;
        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_ADDR: begin
                strb_d.csn  = 1'b0;
                strb_d.advn = 1'b0;
                ad_oe_d     = 1'b1;
                ad_o_d      = DATA_WIDTH'(addr_d);
            end
            ST_DATA: begin
                strb_d.csn = 1'b0;
                if (we_d) begin
                    strb_d.wein = 1'b0;
                    ad_oe_d     = 1'b1;
                    ad_o_d      = wdata_d;
                end else begin
                    // Driver released in the same cycle oen falls.
                    strb_d.oen = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ph_cnt_q    <= '0;
            strb_q      <= STROBES_IDLE;
            ad_oe_q     <= 1'b0;
            ad_o_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            strb_q      <= strb_d;
            ad_oe_q     <= ad_oe_d;
            ad_o_q      <= ad_o_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    // NOTE: the latched request payload has no reset; it is always loaded at
    // accept before anything downstream looks at it.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign gpmc_csn   = strb_q.csn;
    assign gpmc_advn  = strb_q.advn;
    assign gpmc_wein  = strb_q.wein;
    assign gpmc_oen   = strb_q.oen;
    assign gpmc_ad_oe = ad_oe_q;
    assign gpmc_ad_o  = ad_o_q;

endmodule

// File: tb/tb_gpmc_master.sv
// tb_gpmc_master: self-checking bench for gpmc_master.
// u_dut uses default timing; u_slow uses CLK_HALF=2, RD_LAT=3.
// Build with GPMC_WAIT_EN defined to include the wait-extension sequence.
module tb_gpmc_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        gpmc_clk, gpmc_csn, gpmc_advn, gpmc_wein, gpmc_oen, gpmc_ad_oe;
    logic [15:0] gpmc_ad_o, gpmc_ad_i;

    logic        s_req_valid, s_req_ready, s_req_we;
    logic [3:0]  s_req_addr;
    logic [15:0] s_req_wdata;
    logic        s_rsp_valid;
    logic [15:0] s_rsp_rdata;
    logic        s_gclk, s_csn, s_advn, s_wein, s_oen, s_ad_oe;
    logic [15:0] s_ad_o, s_ad_i;
`ifdef GPMC_WAIT_EN
    logic        gpmc_wait, s_wait;
`endif

    gpmc_master u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .gpmc_clk   (gpmc_clk),
        .gpmc_csn   (gpmc_csn),
        .gpmc_advn  (gpmc_advn),
        .gpmc_wein  (gpmc_wein),
        .gpmc_oen   (gpmc_oen),
        .gpmc_ad_o  (gpmc_ad_o),
        .gpmc_ad_oe (gpmc_ad_oe),
        .gpmc_ad_i  (gpmc_ad_i)
`ifdef GPMC_WAIT_EN
        ,
        .gpmc_wait  (gpmc_wait)
`endif
    );

    gpmc_master #(
        .CLK_HALF (2),
        .RD_LAT   (3)
    ) u_slow (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (s_req_valid),
        .req_ready  (s_req_ready),
        .req_we     (s_req_we),
        .req_addr   (s_req_addr),
        .req_wdata  (s_req_wdata),
        .rsp_valid  (s_rsp_valid),
        .rsp_rdata  (s_rsp_rdata),
        .gpmc_clk   (s_gclk),
        .gpmc_csn   (s_csn),
        .gpmc_advn  (s_advn),
        .gpmc_wein  (s_wein),
        .gpmc_oen   (s_oen),
        .gpmc_ad_o  (s_ad_o),
        .gpmc_ad_oe (s_ad_oe),
        .gpmc_ad_i  (s_ad_i)
`ifdef GPMC_WAIT_EN
        ,
        .gpmc_wait  (s_wait)
`endif
    );

    typedef struct packed {
        logic        ready;
        logic        rsp;
        logic        gclk;
        logic        csn;
        logic        advn;
        logic        wein;
        logic        oen;
        logic        ad_oe;
        logic [15:0] ad_o;
    } bus_t;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] bus_rd;     // value the bench presents on AD at the sample point
        logic [15:0] exp_rdata;  // rsp_rdata expected at completion
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bus_t sample();
        bus_t s;
        s.ready = req_ready;  s.rsp  = rsp_valid; s.gclk  = gpmc_clk;
        s.csn   = gpmc_csn;   s.advn = gpmc_advn; s.wein  = gpmc_wein;
        s.oen   = gpmc_oen;   s.ad_oe = gpmc_ad_oe; s.ad_o = gpmc_ad_o;
        return s;
    endfunction

    function automatic bus_t idle_bus(input logic ready);
        bus_t m;
        m.ready = ready; m.rsp = 1'b0; m.gclk = 1'b0;
        m.csn = 1'b1; m.advn = 1'b1; m.wein = 1'b1; m.oen = 1'b1;
        m.ad_oe = 1'b0; m.ad_o = '0;
        return m;
    endfunction

    // Expected default-timing bus state k cycles after accept (P = 2 cycles).
    function automatic bus_t model(input int k, input vec_t v, input int ext);
        bus_t m;
        int   d1;
        d1 = 2 + 2 * ((v.we ? 1 : 2) + ext);
        m  = idle_bus(k >= d1 + 3);
        if (k < d1 + 3) begin
            m.gclk = (k % 2 == 0);
            if (k <= 2) begin
                m.csn = 1'b0; m.advn = 1'b0; m.ad_oe = 1'b1; m.ad_o = {12'h000, v.addr};
            end else if (k <= d1) begin
                m.csn = 1'b0;
                if (v.we) begin
                    m.wein = 1'b0; m.ad_oe = 1'b1; m.ad_o = v.wdata;
                end else begin
                    m.oen = 1'b0;
                end
            end else begin
                m.rsp = (k == d1 + 1);
            end
        end
        return m;
    endfunction

    // Scoreboard: one expected rsp_rdata per accepted request.
    always @(negedge clk) begin : sb_mon
        logic [15:0] e;
        if (!rst && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e);
            end
        end
    end

    // Called at a negedge; returns just after the accepting posedge.
    task automatic start(input vec_t v, output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        while (req_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) check("accept_timeout", req_ready, 1'b1);
        else sb_q.push_back(v.exp_rdata);
        @(posedge clk);
    endtask

    // Checks every cycle of an access; with hold, keeps req_valid high with
    // junk payload and presents nxt just before the next accept.
    task automatic watch(input vec_t v, input int ext, input bit hold, input vec_t nxt);
        int d1, last;
        d1   = 2 + 2 * ((v.we ? 1 : 2) + ext);
        last = d1 + 3;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            check($sformatf("%s_a%0h_k%0d", v.we ? "wr" : "rd", v.addr, k), sample(), model(k, v, ext));
            gpmc_ad_i = (k == d1 - 1 || k == d1) ? v.bus_rd : (16'hDEAD ^ 16'(k));
`ifdef GPMC_WAIT_EN
            gpmc_wait = (k >= 3 && k < 3 + 2 * ext);
`endif
            if (!hold) begin
                req_valid = 1'b0;
            end else if (k == last - 1) begin
                req_we = nxt.we; req_addr = nxt.addr; req_wdata = nxt.wdata;
            end else if (k < last - 1) begin
                req_we = 1'($urandom); req_addr = 4'($urandom); req_wdata = 16'($urandom);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t a, b, r;
        int   waited;
        logic [5:0] s_exp;

        tbl[0] = '{we:1'b1, addr:4'h3, wdata:16'hA5C3, bus_rd:16'h0000, exp_rdata:16'h0000};
        tbl[1] = '{we:1'b0, addr:4'h5, wdata:16'h0000, bus_rd:16'h1234, exp_rdata:16'h1234};
        tbl[2] = '{we:1'b1, addr:4'hF, wdata:16'hFFFF, bus_rd:16'h0000, exp_rdata:16'h1234};
        tbl[3] = '{we:1'b0, addr:4'h0, wdata:16'h0000, bus_rd:16'h8001, exp_rdata:16'h8001};
        tbl[4] = '{we:1'b1, addr:4'h0, wdata:16'h0000, bus_rd:16'h0000, exp_rdata:16'h8001};
        tbl[5] = '{we:1'b0, addr:4'hA, wdata:16'h0000, bus_rd:16'h5A5A, exp_rdata:16'h5A5A};
        a = '{we:1'b1, addr:4'h6, wdata:16'h1357, bus_rd:16'h0000, exp_rdata:16'h5A5A};
        b = '{we:1'b1, addr:4'h9, wdata:16'h2468, bus_rd:16'h0000, exp_rdata:16'h5A5A};
        r = '{we:1'b0, addr:4'h7, wdata:16'h0000, bus_rd:16'h7777, exp_rdata:16'h0000};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; gpmc_ad_i = '0;
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_addr = '0; s_req_wdata = '0; s_ad_i = '0;
`ifdef GPMC_WAIT_EN
        gpmc_wait = 1'b0; s_wait = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_bus", sample(), idle_bus(1'b0));
        check("reset_rdata", rsp_rdata, 16'h0000);
        check("reset_slow", {s_req_ready, s_rsp_valid, s_gclk, s_csn, s_advn, s_wein, s_oen, s_ad_oe},
              8'b0001_1110);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", sample(), idle_bus(1'b1));

        // Table of single accesses
        foreach (tbl[i]) begin
            start(tbl[i], waited);
            watch(tbl[i], 0, 1'b0, tbl[i]);
        end

        // req_valid held high: second write accepted right as TURN ends
        start(a, waited);
        watch(a, 0, 1'b1, b);
        start(b, waited);
        check("b2b_no_wait", waited, 0);
        watch(b, 0, 1'b0, b);

`ifdef GPMC_WAIT_EN
        // Wait high at the first two DATA period ends: DATA 3 periods
        begin
            vec_t w;
            w = '{we:1'b1, addr:4'hC, wdata:16'h0F0F, bus_rd:16'h0000, exp_rdata:16'h5A5A};
            start(w, waited);
            watch(w, 2, 1'b0, w);
        end
`endif

        // Reset in the middle of a read DATA phase
        start(r, waited);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("rstmid_k%0d", k), sample(), model(k, r, 0));
            if (k == 1) req_valid = 1'b0;
            gpmc_ad_i = 16'h7777;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_idle", sample(), idle_bus(1'b0));
        void'(sb_q.pop_back());
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ready", sample(), idle_bus(1'b1));
        repeat (3) begin
            @(negedge clk);
            check("rstmid_no_rsp", rsp_valid, 1'b0);
        end

        // CLK_HALF=2, RD_LAT=3 read on u_slow: 4-cycle period, DATA cycles 5..16
        check("slow_ready", s_req_ready, 1'b1);
        s_req_valid = 1'b1; s_req_we = 1'b0; s_req_addr = 4'h9;
        @(posedge clk);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            s_exp = {k >= 21, k == 17, (k <= 20) && (((k - 1) % 4) >= 2),
                     !(k <= 16), !(k <= 4), !(k >= 5 && k <= 16)};
            check($sformatf("slow_k%0d", k),
                  {s_req_ready, s_rsp_valid, s_gclk, s_csn, s_advn, s_oen}, s_exp);
            if (k == 17) check("slow_rdata", s_rsp_rdata, 16'hBEEF);
            s_req_valid = 1'b0;
            s_ad_i = (k == 16) ? 16'hBEEF : (16'hBE00 | 16'(k));
        end

        @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpmc_master.md
Name: gpmc_master

Overview:
- Synchronous GPMC initiator that drives the multiplexed address/data bus (ad, advn, csn, wein, oen, gpmc_clk) from a simple request/response interface.
- Used as the host-side model and FPGA-to-FPGA bridge end for our GPMC responder designs, such as the mem-mapped GPIO register bank.
- Issues one single-word read or write per request, with fixed, parameterised phase lengths.

Parameters:
- ADDR_WIDTH, 4: word-address width; must be ≤ DATA_WIDTH.
- DATA_WIDTH, 16: AD bus and data width.
- CLK_HALF, 1: clk cycles per gpmc_clk half-period (≥1). One bus period P = 2*CLK_HALF clk cycles.
- RD_LAT, 2: read data-phase length in periods (≥1).
- WR_HOLD, 1: write data-phase length in periods (≥1).
- TURN, 1: idle periods after each access, with csn high (≥1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads.
- gpmc_clk  out  1  bus clock.
- gpmc_csn  out  1  chip select, active low.
- gpmc_advn  out  1  address valid, active low.
- gpmc_wein  out  1  write enable, active low.
- gpmc_oen  out  1  output enable, active low.
- gpmc_ad_o  out  DATA_WIDTH  AD drive value.
- gpmc_ad_oe  out  1  AD driver enable; the top level builds the tristate.
- gpmc_ad_i  in  DATA_WIDTH  AD sampled value.

Behaviour:
- Reset values:
  - csn = advn = wein = oen = 1.
  - gpmc_clk = 0, gpmc_ad_oe = 0, gpmc_ad_o = 0.
  - rsp_valid = 0, rsp_rdata = 0, req_ready = 0.
  - FSM = IDLE.
- Reset mid-access: the outputs above take effect on the next edge, the access is abandoned, and no rsp_valid is issued.
- FSM states: IDLE → ADDR → DATA → TURN → IDLE.
- Sequencing rules:
  - Every non-IDLE state lasts a whole number of periods.
  - In each period, gpmc_clk is low for the first CLK_HALF cycles and high for the second.
  - State changes occur after the last clk of a period.
  - gpmc_clk is held low in IDLE.
- IDLE:
  - req_ready = 1 (0 in every other state).
  - On accept, latch req_we/addr/wdata and enter ADDR on the next cycle.
  - req_* inputs are ignored outside the accept cycle.
- ADDR, 1 period:
  - csn = 0, advn = 0, ad_oe = 1.
  - ad_o = zero-extended addr.
  - wein = oen = 1.
- DATA, write, WR_HOLD periods: csn = 0, advn = 1, wein = 0, ad_oe = 1, ad_o = wdata.
- DATA, read, RD_LAT periods:
  - csn = 0, advn = 1, oen = 0, ad_oe = 0.
  - gpmc_ad_i is captured into rsp_rdata on the final clk of DATA.
- TURN, TURN periods:
  - csn = 1 and all other strobes deasserted.
  - ad_oe = 0, ad_o = 0.
  - rsp_valid = 1 in the first TURN cycle only, for both reads and writes.
  - rsp_rdata is left unchanged by writes.
- There is no back-to-back overlap; the earliest next accept is the cycle after TURN ends.
- Latency with defaults (accept at cycle 0):
  - Write: ADDR cycles 1–2, DATA 3–4, rsp_valid at 5, req_ready at 7.
  - Read: DATA 3–6, sample at 6, rsp_valid at 7, req_ready at 9.
- Counters are sized for the maximum of RD_LAT, WR_HOLD and TURN and never wrap within a phase.
- ad_oe and oen are never both active; ad_oe drops in the same cycle oen falls.

Optional Feature:
- Macro: GPMC_WAIT_EN.
- Defined:
  - Adds input gpmc_wait (1 bit, active high).
  - gpmc_wait is sampled on the last clk of each DATA period.
  - If it is high, DATA is extended by one more period without consuming the phase count, and the read sample point moves with it.
  - Extension is unbounded.
- Undefined: no gpmc_wait port; DATA length is fixed.

Decomposition:
- Shared package gpmc_pkg holds:
  - State enum (IDLE, ADDR, DATA, TURN).
  - Strobe idle constants.
  - Default timing constants (CLK_HALF, RD_LAT, WR_HOLD, TURN).
- Sub-module gpmc_clkgen:
  - Generates gpmc_clk and a one-cycle period_end tick from CLK_HALF.
  - Runs only when enabled; is held low and reset in IDLE.

Test Plan:
- Write addr=0x3, data=0xA5C3 (defaults) → ADDR cycles 1–2 with ad_o=0x0003, advn=0; wein=0 with ad_o=0xA5C3 in cycles 3–4; rsp_valid at cycle 5; req_ready at cycle 7.
- Read addr=0x5 with the bench driving gpmc_ad_i=0x1234 in cycles 5–6 → oen=0 and ad_oe=0 in cycles 3–6; rsp_valid at cycle 7 with rsp_rdata=0x1234.
- CLK_HALF=2, RD_LAT=3 read → gpmc_clk has a 4-cycle period; DATA lasts 12 cycles; capture on the last one.
- req_valid held high continuously → accepts spaced 7 cycles apart (writes) with no overlap; the second request's fields are latched only at its own accept.
- rst asserted in DATA of a read → next cycle all strobes high, ad_oe=0, gpmc_clk=0; no rsp_valid; req_ready=1 one cycle after rst drops.
- GPMC_WAIT_EN build, gpmc_wait=1 for 2 periods during a write → DATA lasts 3 periods; rsp_valid delayed by 4 cycles.
